// File: rtl/spectrum_frame_packer.sv
// rtl/spectrum_frame_packer.sv - packs a window of FFT magnitude bins into one wide frame word
module spectrum_frame_packer #(
    parameter int BIN_W     = 16,
    parameter int FFT_LEN   = 2048,
    parameter int START_BIN = 1024,
    parameter int N_BINS    = 1024,
    parameter int ORDER     = 0,
    localparam int IDX_W    = $clog2(FFT_LEN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    input  logic [BIN_W-1:0]        s_data,
    input  logic [IDX_W-1:0]        s_index,
    input  logic                    s_last,
    output logic [N_BINS*BIN_W-1:0] m_frame,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    frame_done,
    output logic                    frame_err,
    output logic                    frame_drop
);
    localparam int FW = N_BINS * BIN_W;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FFT_LEN - 1);
    localparam logic [IDX_W-1:0] START_L   = IDX_W'(START_BIN);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(N_BINS - 1);
    localparam logic [IDX_W:0]   WIN_LO    = (IDX_W + 1)'(START_BIN);
    localparam logic [IDX_W:0]   WIN_HI    = (IDX_W + 1)'(START_BIN + N_BINS);

    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] exp_q, exp_d;
    logic [FW-1:0]    cap_q, cap_d;
    logic [FW-1:0]    m_frame_q, m_frame_d;
    logic             m_valid_q, m_valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             drop_q, drop_d;

    // In IDLE only an index-0 beat is taken, and it is judged as if bin 0 were expected
    logic             active, match, ok, is_end, good_end, in_range, load;
    logic [IDX_W-1:0] exp_eff, slot, pos;

    assign active   = s_valid && ((state_q == CAPTURE) || ((state_q == IDLE) && (s_index == '0)));
    assign exp_eff  = (state_q == IDLE) ? '0 : exp_q;
    assign match    = (s_index == exp_eff);
    assign ok       = active && match;
    assign is_end   = (s_index == LAST_IDX);
    assign good_end = ok && s_last && is_end;
    assign in_range = ({1'b0, s_index} >= WIN_LO) && ({1'b0, s_index} < WIN_HI);
    assign slot     = s_index - START_L;
    assign pos      = (ORDER != 0) ? slot : (LAST_SLOT - slot);
    assign load     = good_end && (!m_valid_q || m_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
        end
    end

    always_ff @(posedge clk) begin
        cap_q <= cap_d;
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        case (state_q)
            IDLE, CAPTURE: begin
                if (ok) begin
                    exp_d   = s_index + IDX_W'(1);
                    state_d = (s_last || is_end) ? IDLE : CAPTURE;
                end else if (active) begin
                    state_d = s_last ? IDLE : FLUSH;
                end
            end
            FLUSH: begin
                if (s_valid && s_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cap_d = cap_q;
        if (ok && in_range) begin
            for (int k = 0; k < N_BINS; k++) begin
                if (pos == IDX_W'(k)) cap_d[k*BIN_W +: BIN_W] = s_data;
            end
        end
        m_frame_d = load ? cap_d : m_frame_q;
        m_valid_d = load || (m_valid_q && !m_ready);
        done_d    = load;
        err_d     = (active && !match) || (ok && (s_last != is_end));
        drop_d    = good_end && !load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_frame_q <= '0;
            m_valid_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            m_frame_q <= m_frame_d;
            m_valid_q <= m_valid_d;
            done_q    <= done_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
        end
    end

    assign m_frame    = m_frame_q;
    assign m_valid    = m_valid_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign frame_drop = drop_q;
endmodule

// File: tb/tb_spectrum_frame_packer.sv
// tb/tb_spectrum_frame_packer.sv - self-checking bench for spectrum_frame_packer
module tb_spectrum_frame_packer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         s_valid = 1'b0;
    logic [15:0]  s_data = '0;
    logic [3:0]   s_index = '0;
    logic         s_last = 1'b0;
    logic         m_ready = 1'b0;
    logic [127:0] m_frame0, m_frame1;
    logic         m_valid0, m_valid1;
    logic         frame_done0, frame_done1;
    logic         frame_err0, frame_err1;
    logic         frame_drop0, frame_drop1;

    int vectors = 0;
    int miscompares = 0;
    int n_done = 0, n_err = 0, n_drop = 0;
    int d0, e0;
    logic [15:0]  fd [16];
    logic [127:0] ones, ramp_exp;

    always #5 clk = ~clk;

    spectrum_frame_packer #(.BIN_W(16), .FFT_LEN(16), .START_BIN(8), .N_BINS(8), .ORDER(0)) dut0 (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_index(s_index),
        .s_last(s_last), .m_frame(m_frame0), .m_valid(m_valid0), .m_ready(m_ready),
        .frame_done(frame_done0), .frame_err(frame_err0), .frame_drop(frame_drop0));

    spectrum_frame_packer #(.BIN_W(16), .FFT_LEN(16), .START_BIN(8), .N_BINS(8), .ORDER(1)) dut1 (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_index(s_index),
        .s_last(s_last), .m_frame(m_frame1), .m_valid(m_valid1), .m_ready(m_ready),
        .frame_done(frame_done1), .frame_err(frame_err1), .frame_drop(frame_drop1));

    always @(negedge clk) begin
        if (frame_done0) n_done++;
        if (frame_err0)  n_err++;
        if (frame_drop0) n_drop++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference packing: window bins 8..15 concatenated in capture order
    function automatic logic [127:0] model(input bit order);
        logic [127:0] f;
        f = '0;
        for (int j = 0; j < 8; j++)
            f = order ? {fd[8+j], f[127:16]} : {f[111:0], fd[8+j]};
        return f;
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) fd[i] = 16'($urandom);
    endtask

    task automatic fill_const(input logic [15:0] v);
        for (int i = 0; i < 16; i++) fd[i] = v;
    endtask

    task automatic beat(input int idx, input logic [15:0] d, input bit last);
        s_valid = 1'b1;
        s_index = 4'(idx);
        s_data  = d;
        s_last  = last;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_index = 4'($urandom);
        s_data  = 16'($urandom);
        s_last  = 1'($urandom);
    endtask

    task automatic send(input int first, input int stop, input int skip, input int last_at,
                        input int err_at, input bit gaps);
        for (int i = first; i <= stop; i++) begin
            if (i == skip) continue;
            beat(i, fd[i], i == last_at);
            if (i == err_at) begin
                chk("err_pulse0", frame_err0, 1);
                chk("err_pulse1", frame_err1, 1);
            end
            if (gaps && i != stop) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_good(input string tag);
        chk({tag, "_done0"}, frame_done0, 1);
        chk({tag, "_done1"}, frame_done1, 1);
        chk({tag, "_valid0"}, m_valid0, 1);
        chk({tag, "_frame0"}, m_frame0, model(1'b0));
        chk({tag, "_frame1"}, m_frame1, model(1'b1));
        chk({tag, "_err0"}, frame_err0, 0);
        chk({tag, "_drop0"}, frame_drop0, 0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        ones     = {8{16'h0001}};
        ramp_exp = 128'h0808_0909_0A0A_0B0B_0C0C_0D0D_0E0E_0F0F;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid0", m_valid0, 0);
        chk("rst_valid1", m_valid1, 0);
        chk("rst_frame0", m_frame0, 0);
        chk("rst_done0", frame_done0, 0);
        chk("rst_err0", frame_err0, 0);
        chk("rst_drop0", frame_drop0, 0);
        reset = 1'b0;

        // Ramp frame, both orderings
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) fd[i] = 16'(i * 16'h0101);
        send(0, 15, -1, 15, -1, 0);
        check_good("ramp");
        chk("ramp_const0", m_frame0, ramp_exp);
        chk("ramp_lsb1", m_frame1[15:0], 16'h0808);
        chk("ramp_msb1", m_frame1[127:112], 16'h0F0F);
        @(posedge clk);
        #1;
        chk("ramp_handshake", m_valid0, 0);

        // Random frames, back-to-back frame boundaries, random gaps inside
        repeat (6) begin
            fill_rand();
            send(0, 15, -1, 15, -1, 1);
            check_good("rand");
        end

        // Backpressure: second frame dropped
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk("bp_idle_valid", m_valid0, 0);
        fill_const(16'h0001);
        send(0, 15, -1, 15, -1, 0);
        check_good("hold1");
        fill_const(16'h0002);
        send(0, 15, -1, 15, -1, 0);
        chk("drop_pulse0", frame_drop0, 1);
        chk("drop_pulse1", frame_drop1, 1);
        chk("drop_nodone", frame_done0, 0);
        chk("drop_keep0", m_frame0, ones);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("hold_valid", m_valid0, 1);
        chk("hold_frame", m_frame0, ones);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_release", m_valid0, 0);
        m_ready = 1'b0;

        // Completion in the same cycle as the handshake of the previous frame
        fill_rand();
        send(0, 15, -1, 15, -1, 0);
        check_good("bp_a");
        fill_rand();
        send(0, 14, -1, -1, -1, 0);
        m_ready = 1'b1;
        send(15, 15, -1, 15, -1, 0);
        check_good("hs_same");

        // Skipped index 5
        settle();
        d0 = n_done;
        e0 = n_err;
        fill_rand();
        send(0, 15, 5, 15, 6, 0);
        settle();
        chk("skip_nodone", n_done, d0);
        chk("skip_errcnt", n_err, e0 + 1);
        fill_rand();
        send(0, 15, -1, 15, -1, 0);
        check_good("after_skip");

        // Early last on index 12, next frame follows immediately
        settle();
        d0 = n_done;
        e0 = n_err;
        fill_rand();
        send(0, 12, -1, 12, 12, 0);
        fill_rand();
        send(0, 15, -1, 15, -1, 0);
        check_good("after_early_last");
        settle();
        chk("early_errcnt", n_err, e0 + 1);
        chk("early_donecnt", n_done, d0 + 1);

        // Final index without last
        e0 = n_err;
        fill_rand();
        send(0, 15, -1, -1, 15, 0);
        fill_rand();
        send(0, 15, -1, 15, -1, 0);
        check_good("after_nolast");
        settle();
        chk("nolast_errcnt", n_err, e0 + 1);

        // Reset mid-frame, tail of the stream must be ignored
        d0 = n_done;
        e0 = n_err;
        fill_rand();
        send(0, 9, -1, -1, -1, 0);
        reset = 1'b1;
        beat(10, fd[10], 1'b0);
        reset = 1'b0;
        chk("midrst_valid", m_valid0, 0);
        chk("midrst_frame", m_frame0, 0);
        send(11, 15, -1, 15, -1, 0);
        settle();
        chk("tail_nodone", n_done, d0);
        chk("tail_noerr", n_err, e0);
        chk("tail_valid", m_valid0, 0);
        fill_rand();
        send(0, 15, -1, 15, -1, 0);
        check_good("after_reset");
        settle();
        chk("reset_errcnt", n_err, e0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
